// File: rtl/onehot_to_bin_pipe.sv
// Two-stage pipelined one-hot to binary decoder with valid/ready on both sides.
// Optional saturating illegal-code counter is built when ONEHOT_ERR_CNT_EN is defined.
module onehot_to_bin_pipe #(
    parameter int WIDTH = 16,
    parameter int BIN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] one_hot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] bin,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    logic             v1;
    logic             v2;
    logic             en1;
    logic             en2;
    logic [WIDTH-1:0] s1_vec;
    logic             s1_zero;
    logic             s1_multi;
    logic [BIN_W-1:0] s2_bin;
    logic             s2_err;
    logic             in_zero;
    logic             in_multi;
    logic [BIN_W-1:0] s1_index;

    // Scanning downwards leaves the lowest set bit as the final winner.
    function automatic logic [BIN_W-1:0] lowest_index(input logic [WIDTH-1:0] vec);
        logic [BIN_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = BIN_W'(i);
            end
        end
        return idx;
    endfunction

    assign en2      = !v2 || out_ready;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign in_zero  = ~|one_hot;
    assign in_multi = |(one_hot & (one_hot - WIDTH'(1)));
    assign s1_index = lowest_index(s1_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            s1_vec   <= '0;
            s1_zero  <= 1'b0;
            s1_multi <= 1'b0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_vec   <= one_hot;
                s1_zero  <= in_zero;
                s1_multi <= in_multi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            s2_bin <= '0;
            s2_err <= 1'b0;
        end else if (en2) begin
            v2     <= v1;
            s2_bin <= s1_zero ? '0 : s1_index;
            s2_err <= s1_zero || s1_multi;
        end
    end

    assign out_valid = v2;
    assign bin       = s2_bin;
    assign err       = s2_err;

`ifdef ONEHOT_ERR_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (v2 && out_ready && s2_err && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign err_count = cnt;
`else
    assign err_count = '0;
`endif

endmodule
